// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared constants and types for synchronous_fifo and its storage array.
//   - DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : default geometry
//   - ptr_width(depth)                   : pointer width, log2(depth)+1
//   - data_t                             : word type at the default width
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  // The extra MSB lets full and empty be told apart when the address bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/synchronous_fifo_mem.sv
// synchronous_fifo_mem
//   DEPTH x DATA_WIDTH register array, one synchronous write port and one
//   synchronous registered read port. Only the read register is reset;
//   the array itself keeps its contents across reset.
//   Ports:
//     clk      in   clock
//     rst      in   async active-low reset (clears rdata only)
//     we_i     in   write strobe
//     waddr_i  in   write address
//     wdata_i  in   write word
//     re_i     in   read strobe
//     raddr_i  in   read address
//     rdata_o  out  registered read word, held when re_i is low
module synchronous_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/synchronous_fifo.sv
// synchronous_fifo
//   Single-clock FIFO with enable-qualified writes and reads. Writes while
//   full and reads while empty are dropped without side effects.
//   DEPTH must be a power of two and at least 2.
//   Optional macro SYNC_FIFO_ERR_FLAGS_EN adds one-cycle overflow/underflow
//   pulse outputs.
//   Ports:
//     clk        in   clock
//     rst        in   async active-low reset
//     w_en       in   write request
//     r_en       in   read request
//     w_data     in   write word
//     r_data     out  registered read word
//     full       out  DEPTH entries stored
//     empty      out  no entries stored
//     overflow   out  (macro only) write attempted while full, no read
//     underflow  out  (macro only) read attempted while empty
module synchronous_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  // Pointers wrap naturally at 2*DEPTH.
  assign wr_ptr_d = wr_ptr_q + PW'(wr_ok);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  synchronous_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (w_data),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (r_data)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // A write into a full FIFO with a read in the same cycle is not an
  // overflow: the read frees the slot's accounting even though the write is
  // still dropped.
  assign overflow_d  = w_en && full && !r_en;
  assign underflow_d = r_en && empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
module tb_synchronous_fifo;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full;
  logic       empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  synchronous_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_en),
    .r_en   (r_en),
    .w_data (w_data),
    .r_data (r_data),
    .full   (full),
    .empty  (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       chk_rd;
    logic [7:0] rd;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] wd,
                      input logic chk_rd, input logic [7:0] rd,
                      input logic f, input logic e, input logic ov, input logic un);
    exp_t x;
    @(negedge clk);
    w_en   = w;
    r_en   = r;
    w_data = wd;
    x.chk_rd = chk_rd; x.rd = rd; x.full = f; x.empty = e; x.ovf = ov; x.unf = un;
    exp_q.push_back(x);
  endtask

  task automatic wait_drained();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
  endtask

  // Monitor: compares the DUT after every edge for which an expectation was queued.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        if (x.chk_rd) check("r_data", r_data, x.rd);
        check("full", full, x.full);
        check("empty", empty, x.empty);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow", overflow, x.ovf);
        check("underflow", underflow, x.unf);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = 8'h00;

    // Reset held for 5 cycles
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_r_data", r_data, 8'h00);
    rst = 1'b1;
    #1;
    check("rel_empty", empty, 1);

    // Reads on empty are dropped
    step(0, 1, 8'h00, 1, 8'h00, 0, 1, 0, 1);
    step(0, 1, 8'h00, 1, 8'h00, 0, 1, 0, 1);

    // Fill 01..08, then a dropped write
    for (int i = 1; i <= 8; i++)
      step(1, 0, 8'(i), 0, 8'h00, (i == 8), 0, 0, 0);
    step(1, 0, 8'hFF, 0, 8'h00, 1, 0, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);

    // Drain 01..08, then a dropped read
    for (int i = 1; i <= 8; i++)
      step(0, 1, 8'h00, 1, 8'(i), 0, (i == 8), 0, 0);
    step(0, 1, 8'h00, 1, 8'h08, 0, 1, 0, 1);
    step(0, 0, 8'h00, 1, 8'h08, 0, 1, 0, 0);

    // Wrap-around: 5 in / 5 out, then 6 across the pointer wrap
    for (int i = 0; i < 5; i++)
      step(1, 0, 8'h10 + 8'(i), 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 8'h00, 1, 8'h10 + 8'(i), 0, (i == 4), 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 0, 8'hA0 + 8'(i), 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 1, 8'h00, 1, 8'hA0 + 8'(i), 0, (i == 5), 0, 0);

    // Simultaneous read+write while full: only the read happens
    for (int i = 1; i <= 8; i++)
      step(1, 0, 8'(i), 0, 8'h00, (i == 8), 0, 0, 0);
    step(1, 1, 8'hEE, 1, 8'h01, 0, 0, 0, 0);
    for (int i = 2; i <= 8; i++)
      step(0, 1, 8'h00, 1, 8'(i), 0, (i == 8), 0, 0);
    step(0, 1, 8'h00, 1, 8'h08, 0, 1, 0, 1);

    // Steady simultaneous traffic at half occupancy
    for (int i = 0; i < 4; i++)
      step(1, 0, 8'h31 + 8'(i), 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 1, 8'h41 + 8'(i), 1, 8'h31 + 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 8'h00, 1, 8'h41 + 8'(i), 0, (i == 3), 0, 0);

    // Simultaneous on empty: only the write happens
    step(1, 1, 8'h55, 1, 8'h44, 0, 0, 0, 1);
    step(0, 1, 8'h00, 1, 8'h55, 0, 1, 0, 0);

    // Reset pulse between edges with 4 words stored
    for (int i = 0; i < 4; i++)
      step(1, 0, 8'h61 + 8'(i), 0, 8'h00, 0, 0, 0, 0);
    step(0, 0, 8'h00, 1, 8'h55, 0, 0, 0, 0);
    wait_drained();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_r_data", r_data, 8'h00);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_underflow", underflow, 0);
`endif
    #1;
    rst = 1'b1;
    step(1, 0, 8'h77, 1, 8'h00, 0, 0, 0, 0);
    step(0, 1, 8'h00, 1, 8'h77, 0, 1, 0, 0);
    step(0, 1, 8'h00, 1, 8'h77, 0, 1, 0, 1);
    step(0, 0, 8'h00, 1, 8'h77, 0, 1, 0, 0);
    wait_drained();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/synchronous_fifo.md
# synchronous_fifo

Single-clock first-in/first-out buffer that decouples a byte producer from a byte consumer in the same clock domain. Writes and reads are enable-qualified. `full` and `empty` are status flags. Overrun and underrun attempts are silently dropped, so neither side needs flow-control logic beyond checking the flags.

## Interface
Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 8: number of entries; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-low: asserted when 0, released synchronously to clk by the system.
- w_en  input  1  write request, sampled on the rising edge of clk.
- r_en  input  1  read request, sampled on the rising edge of clk.
- w_data  input  DATA_WIDTH  write word, captured when a write is accepted.
- r_data  output  DATA_WIDTH  registered read word.
- full  output  1  1 when DEPTH entries are stored.
- empty  output  1  1 when 0 entries are stored.

## Operation
- Write and read pointers are each log2(DEPTH)+1 bits; the extra MSB disambiguates full from empty.
- empty = (wr_ptr == rd_ptr).
- full = (address bits equal) AND (MSBs differ).
- Write acceptance: accepted iff w_en && !full. The word is stored at wr_ptr, then wr_ptr increments.
- Read acceptance: accepted iff r_en && !empty. r_data <= mem[rd_ptr], then rd_ptr increments.
- A write while full is dropped: no state change, stored data untouched.
- A read while empty is dropped: r_data holds its previous value.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both are accepted; occupancy is unchanged.
  - Full: only the read is accepted; the write is dropped and full deasserts.
  - Empty: only the write is accepted; the read is dropped.
- Pointers wrap modulo 2·DEPTH. Memory addressing uses the low log2(DEPTH) bits.
- Reset (rst=0, any time, including mid-transfer):
  - Pointers go to 0, so empty=1 and full=0.
  - r_data goes to 0.
  - Memory contents are not cleared.

## Timing
- full and empty are combinational from registered pointers, so they change only after a clock edge or reset.
- Write to readable: a word written at edge N deasserts empty after edge N. It can be read at edge N+1 at the earliest and appears on r_data after that edge.
- Read latency: 1 cycle. r_data updates on the same edge that accepts the read.
- Filling: DEPTH consecutive accepted writes from empty assert full after the DEPTH-th edge.
- r_data is stable between accepted reads.

## Configuration
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): registered, high for exactly one cycle after an edge where w_en && full && !r_en.
  - underflow (1 bit): registered, high for exactly one cycle after an edge where r_en && empty.
  - Both reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

## Structure
- Package sync_fifo_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - pointer-width constant/function, log2(DEPTH)+1;
  - the data word typedef.
- Sub-module synchronous_fifo_mem: DEPTH x DATA_WIDTH register array with one synchronous write port and one synchronous registered read port.
- The top level holds the pointers, flags and acceptance logic.

## Test plan
- Reset: hold rst=0 for 5 cycles, then release -> empty=1, full=0, r_data=8'h00. Reads issued in the next 2 cycles are dropped and r_data stays 8'h00.
- Fill: 8 writes of 8'h01..8'h08 from empty -> full=1 after the 8th edge. A 9th write of 8'hFF is dropped (overflow=1 for one cycle if enabled).
- Drain: 8 reads after the fill -> r_data sequence 01..08 in order, empty=1 after the 8th read. A 9th read keeps r_data=8'h08 (underflow pulse if enabled).
- Wrap-around: write 5 words, read 5, then write 6 more (8'hA0..8'hA5) and read them back -> exact order preserved across the pointer wrap.
- Simultaneous while full: fill with 01..08, then assert w_en=r_en=1 with 8'hEE -> r_data=8'h01, 8'hEE not stored, full=0 afterwards. Continuous simultaneous traffic at half occupancy keeps the flags constant.
- Reset mid-operation: with 4 words stored, pulse rst=0 between edges -> empty=1, r_data=0 immediately (asynchronous). The next write/read returns only the new data.
